// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and defaults for the two-port SRAM arbiter.
//   own_state_t   : ownership FSM state (IDLE, OWN0, OWN1)
//   SRAM_ADDR_W   : default SRAM address width
//   SRAM_DATA_W   : default SRAM data width
//   own_mask()    : per-state eligibility mask handed to the round-robin picker
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 3;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

    // While a port owns the SRAM only that port may be granted.
    function automatic logic [1:0] own_mask(input own_state_t st);
        logic [1:0] m;
        case (st)
            IDLE:    m = 2'b11;
            OWN0:    m = 2'b01;
            OWN1:    m = 2'b10;
            default: m = 2'b11;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-input round-robin picker.
//   req[1:0]  in  : raw requests
//   last_gnt  in  : port granted most recently (0 or 1)
//   mask[1:0] in  : eligibility from the ownership FSM
//   gnt[1:0]  out : one-hot grant (or zero)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] elig_s;

    assign elig_s = req & mask;

    // Pick the single eligible port; on a tie favour the port not granted last.
    always_comb begin
        gnt = 2'b00;
        case (elig_s)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one simple_sram (sync write, 1-cycle registered read)
// between two masters, one beat per cycle, round-robin with per-port lock.
//   req/we/lock/addr/wdata 0,1  in  : per-port access request
//   gnt0/gnt1                   out : combinational beat acceptance
//   rvalid0/1, rdata0/1         out : registered read response (gnt at T -> rvalid at T+2)
//   sram_wr_en/addr/din         out : SRAM drive
//   sram_dout                   in  : SRAM read data, valid the cycle after issue
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    own_state_t        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_tag_q, rd_tag_d;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [1:0]        arb_gnt_s;
    logic [1:0]        gnt_s;

    rr_arb2 u_rr_arb2 (
        .req      ({req1, req0}),
        .last_gnt (last_gnt_q),
        .mask     (own_mask(state_q)),
        .gnt      (arb_gnt_s)
    );

    // Reset is asynchronous, so grants are gated directly to keep the SRAM
    // untouched while rst_n is low.
    assign gnt_s = arb_gnt_s & {2{rst_n}};
    assign gnt0  = gnt_s[0];
    assign gnt1  = gnt_s[1];

    // SRAM drive mux; idle cycles park on port 0 values with writes disabled.
    always_comb begin
        sram_addr  = addr0;
        sram_din   = wdata0;
        sram_wr_en = 1'b0;
        if (gnt_s[1]) begin
            sram_addr  = addr1;
            sram_din   = wdata1;
            sram_wr_en = we1;
        end else if (gnt_s[0]) begin
            sram_wr_en = we0;
        end else begin
            sram_wr_en = 1'b0;
        end
    end

    // Ownership next state; an owner leaves on any cycle its lock is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_s[0] && lock0) begin
                    state_d = OWN0;
                end else if (gnt_s[1] && lock1) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0:    state_d = lock0 ? OWN0 : IDLE;
            OWN1:    state_d = lock1 ? OWN1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round-robin history and read-issue tracking.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_s[1]) begin
            last_gnt_d = 1'b1;
        end else if (gnt_s[0]) begin
            last_gnt_d = 1'b0;
        end else begin
            last_gnt_d = last_gnt_q;
        end
        rd_pend_d = (gnt_s[0] & ~we0) | (gnt_s[1] & ~we1);
        rd_tag_d  = gnt_s[1];
    end

    // Control state: FSM, round-robin pointer (1 so port 0 wins first), read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    // Response capture: SRAM data is valid in the cycle after issue and is
    // steered to the tagged port; rdata holds between captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rd_pend_q & ~rd_tag_q;
            rvalid1_q <= rd_pend_q & rd_tag_q;
            if (rd_pend_q && !rd_tag_q) begin
                rdata0_q <= sram_dout;
            end
            if (rd_pend_q && rd_tag_q) begin
                rdata1_q <= sram_dout;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural SRAM
// and a read-response scoreboard (port, data, due cycle).
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       sram_wr_en;
    logic [2:0] sram_addr;
    logic [7:0] sram_din;
    logic [7:0] sram_dout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic        port;
        logic [7:0]  data;
        logic [31:0] due;
    } rsp_t;
    rsp_t sb[$];

    logic [7:0] mem [8];

    sram_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .sram_wr_en(sram_wr_en), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // simple_sram model: synchronous write, registered read.
    always @(posedge clk) begin
        if (sram_wr_en) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && (rvalid0 || rvalid1)) begin
            rsp_t e;
            chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
            chk("rvalid_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_port", 32'(rvalid1), 32'(e.port));
                chk("rsp_data", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), e.due);
            end
        end
    end

    // Drive one beat (no wait) and check grant and SRAM drive; reads that are
    // expected to be granted get their response queued.
    task automatic drive_chk(input logic r0, input logic w0, input logic l0,
                             input logic [2:0] a0, input logic [7:0] d0,
                             input logic r1, input logic w1, input logic l1,
                             input logic [2:0] a1, input logic [7:0] d1,
                             input logic [1:0] exp_gnt, input logic [7:0] exp_rd,
                             input string tag);
        rsp_t e;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #2;
        chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'(exp_gnt));
        if (exp_gnt[1]) begin
            chk({tag, "_wren"}, 32'(sram_wr_en), 32'(w1));
            chk({tag, "_addr"}, 32'(sram_addr), 32'(a1));
            if (w1) chk({tag, "_din"}, 32'(sram_din), 32'(d1));
        end else begin
            chk({tag, "_wren"}, 32'(sram_wr_en), 32'(exp_gnt[0] & w0));
            chk({tag, "_addr"}, 32'(sram_addr), 32'(a0));
            if (exp_gnt[0] && w0) chk({tag, "_din"}, 32'(sram_din), 32'(d0));
        end
        if ((exp_gnt[0] && !w0) || (exp_gnt[1] && !w1)) begin
            e.port = exp_gnt[1];
            e.data = exp_rd;
            e.due  = 32'(cyc + 2);
            sb.push_back(e);
        end
    endtask

    task automatic beat(input logic r0, input logic w0, input logic l0,
                        input logic [2:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [2:0] a1, input logic [7:0] d1,
                        input logic [1:0] exp_gnt, input logic [7:0] exp_rd,
                        input string tag);
        @(negedge clk);
        drive_chk(r0, w0, l0, a0, d0, r1, w1, l1, a1, d1, exp_gnt, exp_rd, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                 2'b00, 8'h00, "idle");
    endtask

    initial begin
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 3'd0; addr1 = 3'd0; wdata0 = 8'h00; wdata1 = 8'h00;
        #1 rst_n = 1'b0;

        // Reset: requests present, nothing granted, no write, outputs cleared.
        drive_chk(1'b1, 1'b1, 1'b0, 3'd6, 8'h77, 1'b1, 1'b1, 1'b0, 3'd7, 8'h66,
                  2'b00, 8'h00, "rst");
        @(negedge clk);
        chk("rst_wren_hold", 32'(sram_wr_en), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_chk(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  2'b00, 8'h00, "post_rst");

        // Preload through the arbiter; port 1 last so port 0 wins the next tie.
        beat(1'b1, 1'b1, 1'b0, 3'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'h00, "pre1");
        beat(1'b1, 1'b1, 1'b0, 3'd2, 8'h55, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'h00, "pre2");
        beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h0F, 2'b10, 8'h00, "pre5");

        // Conflict: continuous reads from both ports alternate starting at 0.
        for (int i = 0; i < 4; i++)
            beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00,
                 (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'hAA : 8'h55, "conflict");
        idle(3);

        // Single write then read on port 0.
        beat(1'b1, 1'b1, 1'b0, 3'd3, 8'hF0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'h00, "wr3");
        beat(1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'hF0, "rd3");
        idle(3);

        // Write-then-read hazard across ports.
        beat(1'b1, 1'b1, 1'b0, 3'd3, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'h00, "haz_wr");
        beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 2'b10, 8'h0F, "haz_rd");
        idle(3);

        // Lock / read-modify-write on port 1 while port 0 keeps requesting.
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'hAA, "rmw_pre");
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'h00, 2'b10, 8'h0F, "rmw_rd");
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 8'h10, 2'b10, 8'h00, "rmw_wr");
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'hAA, "rmw_p0");
        beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 2'b10, 8'h10, "rmw_chk");
        idle(3);

        // Idle ownership: port 0 owns with no request, port 1 is locked out.
        beat(1'b1, 1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 2'b01, 8'h55, "own_rd");
        for (int i = 0; i < 4; i++)
            beat(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h99,
                 2'b00, 8'h00, "own_hold");
        beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 2'b00, 8'h00, "own_drop");
        beat(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 2'b10, 8'hAA, "own_p1");
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-read: the in-flight port 0 read must vanish.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 3'd1;
        #2;
        chk("mid_gnt", 32'({gnt1, gnt0}), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        drive_chk(1'b1, 1'b1, 1'b0, 3'd4, 8'h33, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  2'b00, 8'h00, "mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive_chk(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00,
                  2'b00, 8'h00, "mid_rel");
        idle(3);
        chk("mid_rdata0", 32'(rdata0), 32'd0);
        chk("mid_rdata1", 32'(rdata1), 32'd0);
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 2'b01, 8'hAA, "mid_c0");
        beat(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 2'b10, 8'h55, "mid_c1");
        idle(4);
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
